// File: rtl/keypad_entry.sv
// 4x4 hex keypad scanner with debounce, ghost rejection and decimal entry into an 8-bit value.
// Optional build macro KEYPAD_BACKSPACE_EN turns code 0xE into a delete-last-digit key.
module keypad_entry #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned MAX_DIGITS     = 3
) (
  input  logic       CLKK,
  input  logic       RST,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [7:0] number,
  output logic [1:0] digit_count,
  output logic       overflow
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [1:0]       MAX_DIG  = 2'(MAX_DIGITS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_e;

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic [3:0]       col_out_q;
  logic [11:0]      cap_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             accept_c;

  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [7:0]       number_q, number_d;
  logic [1:0]       digit_count_q, digit_count_d;
  logic             overflow_q, overflow_d;

  logic [15:0]      low_c;
  logic             scan_done_c, single_c;
  logic [3:0]       hit_code_c;
  logic [11:0]      prod_c;

  // Row synchroniser, column dwell divider and per-column row capture
  always_ff @(posedge CLKK) begin
    if (RST) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      div_q     <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1110;
      cap_q     <= '0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        case (col_q)
          2'd0:    cap_q[3:0]  <= ~row_s2_q;
          2'd1:    cap_q[7:4]  <= ~row_s2_q;
          2'd2:    cap_q[11:8] <= ~row_s2_q;
          default: ;
        endcase
        col_q     <= col_q + 2'd1;
        col_out_q <= {col_out_q[2:0], col_out_q[3]};
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Column 3 is folded in live so the result is ready on the completing edge
  assign low_c       = {~row_s2_q, cap_q};
  assign scan_done_c = (div_q == DIV_LAST) && (col_q == 2'd3);
  assign single_c    = (low_c != 16'd0) && ((low_c & (low_c - 16'd1)) == 16'd0);

  always_comb begin
    hit_code_c = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (low_c[i]) hit_code_c = {2'(i % 4), 2'(i / 4)};
    end
  end

  always_ff @(posedge CLKK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_c = 1'b0;
    if (scan_done_c) begin
      case (state_q)
        IDLE: begin
          if (single_c) begin
            state_d = DEBOUNCE;
            cand_d  = hit_code_c;
            cnt_d   = CNT_W'(1);
          end
        end
        DEBOUNCE: begin
          if (single_c && (hit_code_c == cand_q)) begin
            if (cnt_q + CNT_W'(1) == CNT_LAST) begin
              state_d  = HELD;
              cnt_d    = '0;
              accept_c = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // cnt_q counts consecutive empty scans; any key restarts it
          if (single_c) begin
            cnt_d = '0;
          end else if (cnt_q + CNT_W'(1) == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign prod_c = 12'(number_q) * 12'd10 + 12'(cand_q);

  always_comb begin
    key_valid_d   = accept_c;
    key_code_d    = key_code_q;
    number_d      = number_q;
    digit_count_d = digit_count_q;
    overflow_d    = overflow_q;
    if (accept_c) begin
      key_code_d = cand_q;
      if (cand_q <= 4'd9) begin
        if ((digit_count_q < MAX_DIG) && (prod_c <= 12'd255)) begin
          number_d      = prod_c[7:0];
          digit_count_d = digit_count_q + 2'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (cand_q == 4'hF) begin
        number_d      = 8'd0;
        digit_count_d = 2'd0;
        overflow_d    = 1'b0;
      end
`ifdef KEYPAD_BACKSPACE_EN
      else if ((cand_q == 4'hE) && (digit_count_q != 2'd0)) begin
        number_d      = number_q / 8'd10;
        digit_count_d = digit_count_q - 2'd1;
        overflow_d    = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLKK) begin
    if (RST) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'd0;
      number_q      <= 8'd0;
      digit_count_q <= 2'd0;
      overflow_q    <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      number_q      <= number_d;
      digit_count_q <= digit_count_d;
      overflow_q    <= overflow_d;
    end
  end

  assign col_out     = col_out_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign number      = number_q;
  assign digit_count = digit_count_q;
  assign overflow    = overflow_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Input-side counterpart of the multiplexed 7-seg display path. The display path turns a binary value into strobed digits; this block strobes a 4x4 hex keypad and turns key presses back into a binary value.
- Drives one active-low column at a time and samples active-low rows.
- Debounces and rejects ghost presses.
- Accumulates decimal digits into an 8-bit number (0..255) that feeds the display's `number` input directly.

Parameters:
- SCAN_DIV, 50000: CLKK cycles each column is driven (dwell).
- DEBOUNCE_SCANS, 4: consecutive identical full-scan results required to accept a press or a release.
- MAX_DIGITS, 3: maximum decimal digits accepted.

Ports:
- CLKK  in  1  system clock
- RST  in  1  reset; synchronous, active-high
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to CLKK
- col_out  out  4  keypad column drive, active-low, exactly one bit low
- key_valid  out  1  one-cycle pulse when a press is accepted
- key_code  out  4  code of last accepted key, {row_idx[1:0], col_idx[1:0]}
- number  out  8  accumulated binary value
- digit_count  out  2  digits currently entered (0..MAX_DIGITS)
- overflow  out  1  sticky flag: a digit was rejected

Behaviour:
- Reset (RST high at a CLKK edge):
  - col_out=4'b1110, key_valid=0, key_code=0, number=0, digit_count=0, overflow=0.
  - Divider=0, scan column=0, FSM=IDLE, debounce count=0.
  - Reset mid-scan or mid-debounce discards all partial state.
- Synchroniser: row_in passes through a 2-flop synchroniser. All decisions use the synchronised value.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1 the synchronised rows for the current column are captured, then the column advances 0→1→2→3→0.
  - col_out patterns: 1110, 1101, 1011, 0111.
- Scan result (formed after column 3 is captured):
  - NONE if no row was low in any column.
  - KEY(code) if exactly one (row,col) was low in the whole scan.
  - GHOST if two or more were low; GHOST is treated as NONE.
- FSM, evaluated once per completed scan:
  - IDLE: KEY(c) → DEBOUNCE with cand=c, cnt=1.
  - DEBOUNCE:
    - KEY(cand) → cnt+1.
    - Any other result → IDLE.
    - When cnt reaches DEBOUNCE_SCANS → HELD. On that same clock: key_valid=1 for one cycle, key_code=cand, digit logic applied.
  - HELD:
    - Any KEY result (including a different key) resets the release count. No new key_valid while HELD.
    - NONE for DEBOUNCE_SCANS consecutive scans → IDLE.
- Latency: key_valid asserts DEBOUNCE_SCANS scans after the first scan containing the key, on the clock the final scan completes. number, digit_count and overflow update on that same clock.
- Digit logic (on accept):
  - Keys map to digits 0-9 by code: code 0..9 = digit 0..9.
  - Digit d is accepted only if digit_count<MAX_DIGITS and number*10+d ≤ 255. Then number←number*10+d and digit_count+1.
  - Otherwise number is unchanged and overflow←1. Example: number=25, d=6 gives 256, which is rejected.
  - Arithmetic uses a 12-bit intermediate; there is no truncation.
  - Code 0xF = clear: number=0, digit_count=0, overflow=0.
  - Codes 0xA-0xE pulse key_valid and update key_code with no entry change (0xE: see optional feature).
  - Leading zero: digit 0 with number=0 still increments digit_count.

Optional Feature:
- Macro KEYPAD_BACKSPACE_EN.
- Defined: code 0xE deletes the last digit: number←number/10 (integer), digit_count−1, overflow←0. With digit_count=0 it is a no-op apart from the key_valid pulse. Division is by a fixed constant and completes in the same accept clock.
- Undefined: 0xE behaves like 0xA-0xD (key_valid and key_code only).

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_SCANS=2):
- Reset then idle rows=4'hF → col_out cycles 1110,1101,1011,0111 with 4 clocks each; key_valid never asserts; number=0.
- Press code 2, then release; press 5, release; press 5, release → three key_valid pulses; number=25, then 255, with digit_count=3. A 4th digit 1 → number stays 255, overflow=1.
- Code 0xF → number=0, digit_count=0, overflow=0. Then digits 2,5,6 → number=25 and overflow=1 after 6.
- Bounce: key present in 1 scan, absent for 1, present for 2 → exactly one key_valid, on the clock the 2nd consecutive scan completes. Holding the key for 20 scans → no further pulse.
- Ghost: codes 1 and 6 pressed together → no key_valid. Assert RST mid-DEBOUNCE → all outputs return to reset values on the next clock and scanning restarts at col_out=1110.
- KEYPAD_BACKSPACE_EN defined: enter 1,2,3 then 0xE → number=12, digit_count=2. Undefined: same sequence → number=123, key_code=0xE.
